msk_hpc2_feeder: RTL

Upstream operand and randomness feeder for one HPC2 masked AND gadget with split latency: `ina` and `inb_prev` enter one cycle after `inb` and `rnd`, and the output appears two cycles after `inb`. The block accepts a pair of `d`-share operands through a valid/ready handshake and retimes them to the gadget's per-port latencies. It supplies fresh `hpc2rnd` random bits per operation from an internal seeded 64-bit LFSR, and flags the cycle in which the gadget output is valid.

---
 rtl/msk_hpc2_feeder.sv | 90 +++++++++
 1 files changed

// File: rtl/msk_hpc2_feeder.sv
// msk_hpc2_feeder: retimes d-share operands and LFSR randomness to the split latencies of one HPC2 AND gadget
//   ports: clk, rst (async active-high); seed_valid/seed load the PRNG and start warm-up; seeded high in READY;
//   in_valid/in_ready operand handshake with a_in/b_in shares; inb/rnd stage 0, ina/inb_prev stage 1;
//   res_valid flags the cycle the gadget output is valid
module msk_hpc2_feeder #(
  parameter int d = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       seed_valid,
  input  logic [63:0]                seed,
  output logic                       seeded,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [d-1:0]               a_in,
  input  logic [d-1:0]               b_in,
  output logic [d-1:0]               ina,
  output logic [d-1:0]               inb,
  output logic [d-1:0]               inb_prev,
  output logic [d*(d-1)/2-1:0]       rnd,
  output logic                       res_valid
);
  localparam int RW = d * (d - 1) / 2;
  localparam int WC = (128 + RW - 1) / RW;
  typedef enum logic [1:0] {UNSEEDED, WARMUP, READY} state_t;
  state_t state, state_nx;
  logic [63:0] s, s_adv;
  logic [RW-1:0] cand;
  logic [7:0] cnt, cnt_nx;
  logic [d-1:0] a0;
  logic v0, v1, accept;
  assign seeded = state == READY;
  assign in_ready = seeded;
  assign accept = in_valid && seeded;
  // RW LFSR steps unrolled per cycle; the bit emitted by step k is candidate bit k
  always_comb begin
    s_adv = s;
    cand = '0;
    for (int k = 0; k < RW; k++) begin
      cand[k] = s_adv[63];
      s_adv = {s_adv[62:0], s_adv[63] ^ s_adv[62] ^ s_adv[60] ^ s_adv[59]};
    end
  end
  // reseed wins over warm-up completion
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (seed_valid) begin
      state_nx = WARMUP;
      cnt_nx = '0;
    end else if (state == WARMUP) begin
      cnt_nx = cnt + 8'd1;
      state_nx = cnt_nx == 8'(WC) ? READY : WARMUP;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UNSEEDED;
      cnt <= '0;
      s <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (seed_valid) s <= seed == 64'h0 ? 64'h1 : seed;
      else if (state != UNSEEDED) s <= s_adv;
    end
  end
  // idle cycles zero the shares so stale masked values never reach the gadget
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inb <= '0;
      a0 <= '0;
      rnd <= '0;
      v0 <= 1'b0;
      ina <= '0;
      inb_prev <= '0;
      v1 <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      inb <= accept ? b_in : '0;
      a0 <= accept ? a_in : '0;
      rnd <= accept ? cand : '0;
      v0 <= accept;
      ina <= a0;
      inb_prev <= inb;
      v1 <= v0;
      res_valid <= v1;
    end
  end
endmodule
